// File: rtl/sram_1rw_host_ctrl.sv
// Host-side initiator for a single-port 1RW SRAM macro: request stream in, macro pins out, read data back.
// Reads return 2+ cycles after accept; req_ready is a credit on response slots so the FIFO never overflows.
module sram_1rw_host_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 6,
  parameter int RSP_DEPTH     = 4,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  sweep_fin, sweep_fin_nxt;
  logic                  init_done_nxt;
  logic                  csb_nxt, web_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] din_nxt;
  logic                  rd_iss, rd_iss_nxt, rd_mac;

  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, outstanding;
  logic                  req_fire, push, pop;

  // Every read in the pipe already owns a FIFO slot; writes are gated too so order stays simple.
  assign outstanding = count + CW'(rd_iss) + CW'(rd_mac);
  assign req_ready   = init_done && (outstanding < CW'(RSP_DEPTH));
  assign req_fire    = req_valid && req_ready;

  assign push      = rd_mac;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = (count != '0);
  assign rsp_rdata = fifo_mem[rd_ptr];

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      sweep_fin <= 1'b0;
      init_done <= 1'b0;
      csb0      <= 1'b1;
      web0      <= 1'b1;
      addr0     <= '0;
      din0      <= '0;
      rd_iss    <= 1'b0;
      rd_mac    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sweep_fin <= sweep_fin_nxt;
      init_done <= init_done_nxt;
      csb0      <= csb_nxt;
      web0      <= web_nxt;
      addr0     <= addr_nxt;
      din0      <= din_nxt;
      rd_iss    <= rd_iss_nxt;
      rd_mac    <= rd_iss;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    sweep_fin_nxt = sweep_fin;
    init_done_nxt = init_done;
    csb_nxt       = 1'b1;
    web_nxt       = 1'b1;
    addr_nxt      = addr0;
    din_nxt       = din0;
    rd_iss_nxt    = 1'b0;
    case (state)
      INIT: begin
        if (INIT_ON_RESET == 0 || sweep_fin) begin
          state_nxt     = RUN;
          init_done_nxt = 1'b1;
        end else begin
          csb_nxt  = 1'b0;
          web_nxt  = 1'b0;
          din_nxt  = '0;
          addr_nxt = cnt;
          // Counter parks on the last address; sweep_fin marks the sweep as issued.
          if (cnt == LAST_ADDR) begin
            sweep_fin_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + ADDR_WIDTH'(1);
          end
        end
      end
      RUN: begin
        if (req_fire) begin
          csb_nxt    = 1'b0;
          web_nxt    = ~req_we;
          addr_nxt   = req_addr;
          din_nxt    = req_wdata;
          rd_iss_nxt = ~req_we;
        end
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // dout0 is only looked at in the macro-stage read cycle, so idle-cycle X never enters the FIFO.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= dout0;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  rsp_fifo_no_overflow: assert property (@(posedge clk0) disable iff (!rst_n)
    !(push && !pop && (count == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_sram_1rw_host_ctrl.sv
// Bench for sram_1rw_host_ctrl: behavioural 1RW macro, reference memory and in-order response scoreboard.
module tb_sram_1rw_host_ctrl;

  typedef struct {
    logic [31:0] data;
    int          acc;
  } exp_t;

  logic        clk0 = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        init_done, csb0, web0;
  logic [5:0]  addr0;
  logic [31:0] din0, dout0;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [5:0]  b_req_addr;
  logic [31:0] b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready;
  logic [31:0] b_rsp_rdata;
  logic        b_init_done, b_csb0, b_web0;
  logic [5:0]  b_addr0;
  logic [31:0] b_din0, b_dout0;

  int          nerr = 0;
  int          nchk = 0;
  int          cyc = 0;
  exp_t        sb[$];
  exp_t        e;
  int          rsp_cyc[$];
  logic [31:0] ref_mem [64];

  logic [31:0] macro_mem [64];
  logic        m_act, m_we;
  logic [5:0]  m_addr;
  logic [31:0] m_din;

  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc <= cyc + 1;

  sram_1rw_host_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .RSP_DEPTH(4), .INIT_ON_RESET(1)) dut (
    .clk0(clk0), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done), .csb0(csb0), .web0(web0), .addr0(addr0),
    .din0(din0), .dout0(dout0)
  );

  sram_1rw_host_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .RSP_DEPTH(4), .INIT_ON_RESET(0)) dut_noinit (
    .clk0(clk0), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .init_done(b_init_done), .csb0(b_csb0), .web0(b_web0), .addr0(b_addr0),
    .din0(b_din0), .dout0(b_dout0)
  );

  // Macro: samples pins at posedge, commits/drives dout0 after the following negedge.
  initial begin
    for (int i = 0; i < 64; i++) macro_mem[i] = 32'hA5A50000 | 32'(i);
    dout0 = 32'h0;
  end
  always @(posedge clk0) begin
    m_act  <= !csb0;
    m_we   <= !web0;
    m_addr <= addr0;
    m_din  <= din0;
  end
  always @(negedge clk0) begin
    if (m_act && m_we) macro_mem[m_addr] <= m_din;
    if (m_act && !m_we) dout0 <= macro_mem[m_addr];
    else dout0 <= 32'hBAD0BAD0 ^ 32'(cyc);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: accepted requests update the reference / push expectations; handshakes pop.
  always @(negedge clk0) begin
    if (rst_n) begin
      if (req_valid && req_ready) begin
        if (req_we) ref_mem[req_addr] = req_wdata;
        else sb.push_back('{data: ref_mem[req_addr], acc: cyc + 1});
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check_eq("spurious_rsp", rsp_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check_eq("rsp_data", rsp_rdata, e.data);
          check_eq("rsp_latency_ge2", 1'((cyc - e.acc) >= 2), 1'b1);
        end
      end
    end
  end

  task automatic send(input logic we, input logic [5:0] a, input logic [31:0] d);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk0);
    while (!req_ready && n < 100) begin
      @(negedge clk0);
      n++;
    end
    check_eq("send_accept", req_ready, 1'b1);
    @(posedge clk0); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 100) begin
      @(negedge clk0);
      n++;
    end
    check_eq("drain_empty", sb.size(), 0);
  endtask

  // Called right after rst_n rises at a negedge.
  task automatic check_init();
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk0);
      if (csb0 !== 1'b0 || web0 !== 1'b0 || din0 !== 32'h0 || addr0 !== 6'(i) ||
          init_done !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0 ||
          b_csb0 !== 1'b1 || b_web0 !== 1'b1) bad++;
      if (i == 0) begin
        check_eq("noinit_done", b_init_done, 1'b1);
        check_eq("noinit_req_ready", b_req_ready, 1'b1);
        check_eq("noinit_pins", {b_addr0, b_din0, b_rsp_valid, b_rsp_rdata}, 64'h0);
      end
    end
    check_eq("init_sweep_bad_cycles", bad, 0);
    @(negedge clk0);
    check_eq("init_done", init_done, 1'b1);
    check_eq("init_csb_idle", csb0, 1'b1);
    check_eq("init_req_ready", req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, nacc;
    logic took;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
    b_dout0 = 32'h0;

    repeat (3) @(negedge clk0);
    check_eq("rst_csb0", csb0, 1'b1);
    check_eq("rst_web0", web0, 1'b1);
    check_eq("rst_addr0", addr0, 6'h0);
    check_eq("rst_din0", din0, 32'h0);
    check_eq("rst_req_ready", req_ready, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst_init_done", init_done, 1'b0);
    check_eq("rst_noinit_done", b_init_done, 1'b0);
    rst_n = 1'b1;
    check_init();

    // Zero-fill visible at the top address
    send(1'b0, 6'h3F, 32'h0);
    wait_drain();

    // Write then read same address next cycle; exact 2-cycle latency
    send(1'b1, 6'h05, 32'hDEADBEEF);
    send(1'b0, 6'h05, 32'h0);
    @(negedge clk0); check_eq("lat_n0_valid", rsp_valid, 1'b0);
    @(negedge clk0); check_eq("lat_n1_valid", rsp_valid, 1'b0);
    @(negedge clk0); check_eq("lat_n2_valid", rsp_valid, 1'b1);
    check_eq("lat_n2_data", rsp_rdata, 32'hDEADBEEF);
    wait_drain();

    // Pattern fill then back-to-back reads
    for (int i = 0; i < 8; i++) send(1'b1, 6'(i), 32'(i) * 32'h01010101);
    rsp_cyc.delete();
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(1'b0, 6'(i), 32'h0);
    check_eq("b2b_accept_cycles", cyc - t0, 8);
    wait_drain();
    check_eq("b2b_rsp_count", rsp_cyc.size(), 8);
    for (int i = 1; i < rsp_cyc.size(); i++) check_eq("b2b_rsp_gap", rsp_cyc[i] - rsp_cyc[i-1], 1);

    // Backpressure: credit allows exactly RSP_DEPTH reads
    @(posedge clk0); #1;
    rsp_ready = 1'b0; nacc = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h01;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk0);
      took = req_ready;
      if (took) nacc++;
      @(posedge clk0); #1;
      if (took) req_addr = req_addr + 6'h1;
    end
    req_valid = 1'b0;
    check_eq("bp_accepted", nacc, 4);
    check_eq("bp_req_ready_low", req_ready, 1'b0);
    @(negedge clk0);
    check_eq("bp_head", rsp_rdata, sb[0].data);
    repeat (3) @(negedge clk0);
    check_eq("bp_hold_valid", rsp_valid, 1'b1);
    check_eq("bp_hold_data", rsp_rdata, sb[0].data);
    @(posedge clk0); #1;
    rsp_ready = 1'b1;
    wait_drain();
    check_eq("bp_req_ready_back", req_ready, 1'b1);

    // Reset with two reads in the pipe and one FIFO entry
    @(posedge clk0); #1;
    rsp_ready = 1'b0;
    send(1'b0, 6'h01, 32'h0);
    send(1'b0, 6'h02, 32'h0);
    send(1'b0, 6'h03, 32'h0);
    #2;
    check_eq("pre_rst_rsp_valid", rsp_valid, 1'b1);
    check_eq("pre_rst_csb0", csb0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_csb0", csb0, 1'b1);
    check_eq("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("mid_rst_req_ready", req_ready, 1'b0);
    check_eq("mid_rst_init_done", init_done, 1'b0);
    sb.delete();
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk0);
    rst_n = 1'b1;
    check_init();
    repeat (6) @(negedge clk0);
    check_eq("post_rst_no_rsp", rsp_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/sram_1rw_host_ctrl.md
Name: sram_1rw_host_ctrl

Overview:
- Host-side initiator for the team's single-port 1RW OpenRAM macros (64 x 32 FreePDK45 class).
- Converts a valid/ready request stream into macro pin activity: csb0, web0, addr0, din0.
- Captures dout0 at the correct cycle and returns read data on a valid/ready response stream with backpressure.
- Optionally zero-fills the whole macro after reset, before it accepts any traffic.

Parameters:
- DATA_WIDTH, 32, word width; matches macro din0/dout0.
- ADDR_WIDTH, 6, macro address width; depth = 2^ADDR_WIDTH.
- RSP_DEPTH, 4, response FIFO entries; power of two, >= 2.
- INIT_ON_RESET, 1, 1 = zero-fill all words after reset; 0 = skip.

Ports:
- clk0  in  1  clock; same clock as the macro clk0.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready at posedge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  read data consumed when rsp_valid && rsp_ready at posedge.
- rsp_rdata  out  DATA_WIDTH  read data.
- init_done  out  1  high once initialisation is complete.
- csb0  out  1  macro chip select, active low.
- web0  out  1  macro write enable, active low.
- addr0  out  ADDR_WIDTH  macro address.
- din0  out  DATA_WIDTH  macro write data.
- dout0  in  DATA_WIDTH  macro read data.

Behaviour:
- Clock and reset: one clock, clk0; reset is asynchronous, active-low, on rst_n.
- Reset values, applied asynchronously on rst_n low:
  - csb0=1, web0=1, addr0=0, din0=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0.
  - FIFO empty, all in-flight flags 0, FSM in INIT.
- FSM states: INIT, RUN.
  - INIT with INIT_ON_RESET=1: issues writes of 0 to addresses 0..2^ADDR_WIDTH-1, one per cycle (csb0=0, web0=0, din0=0, addr0=counter).
  - After the last address: next cycle csb0=1, init_done=1, state RUN. Sweep occupies 2^ADDR_WIDTH cycles.
  - INIT with INIT_ON_RESET=0: moves to RUN on the first posedge after reset release.
  - req_ready=0 throughout INIT.
- Issue stage: pin outputs are registered.
  - On an accepted request: next cycle csb0=0, web0=~req_we, addr0=req_addr, din0=req_wdata.
  - No accept: csb0=1, web0=1, addr0/din0 hold their previous values.
- Read timing. Request accepted at posedge N:
  - Pins driven after N.
  - Macro samples at N+1 and drives dout0 after negedge N+1.
  - Controller captures dout0 into the FIFO at posedge N+2.
  - rsp_valid can therefore assert after N+2; minimum request-to-response latency is 2 cycles.
- Writes produce no response. The macro commits the write at negedge N+1.
- Ordering: strictly in order. A read issued in any cycle after a write to the same address returns the new data.
- Credit rule:
  - outstanding = issue-stage read flag + macro-stage read flag + FIFO count.
  - req_ready = init_done && (outstanding < RSP_DEPTH), computed from registers only; no combinational path from rsp_ready or req_* to req_ready.
  - The credit gates writes too.
- Response FIFO:
  - Push on a macro-stage read capture; pop on rsp_valid && rsp_ready.
  - Simultaneous push and pop is allowed, including when full or empty.
  - The credit rule guarantees no overflow; an overflow is an assertion failure.
  - rsp_rdata is the head entry. rsp_valid and rsp_rdata hold stable while rsp_ready=0.
- Throughput: with rsp_ready held 1, back-to-back reads or writes sustain 1 request per cycle.
- Address wrap: the INIT counter stops at 2^ADDR_WIDTH-1 and does not wrap.
- Reset mid-operation (rst_n low at any time):
  - Macro deselected immediately.
  - In-flight reads and FIFO contents discarded; no stale rsp_valid after release.
  - INIT re-runs if INIT_ON_RESET=1.
- dout0 is sampled only in macro-stage read cycles. X on dout0 in any other cycle must not propagate.

Test Plan:
- Reset release, INIT_ON_RESET=1, ADDR_WIDTH=6 -> 64 consecutive cycles of csb0=0, web0=0, din0=0, addr0 0..63; then init_done=1; reading addr 0x3F returns 0x00000000.
- Write 0xDEADBEEF to 0x05, then read 0x05 on the next cycle -> rsp_valid 2 cycles after the read accept, rsp_rdata=0xDEADBEEF.
- Write addr i <- i*0x01010101 for i=0..7, then 8 back-to-back reads with rsp_ready=1 -> req_ready stays 1; 8 in-order responses on consecutive cycles.
- rsp_ready=0 with reads streaming -> exactly 4 accepted, then req_ready=0 and rsp_rdata stable. Raise rsp_ready -> all 4 drained in order, req_ready returns 1.
- Assert rst_n low with 2 reads in flight and 1 FIFO entry -> csb0=1 and rsp_valid=0 immediately; after release no response appears and INIT re-runs.
- INIT_ON_RESET=0 -> init_done=1 and req_ready=1 one cycle after reset release; no macro activity during that cycle.
